// File: rtl/vpu_out_collector.sv
// Purpose: per-lane deskew FIFO with a bypass path, so a datum can leave in the cycle it arrives.
// Latency: 0 cycles from push to head (bypass when empty); entries otherwise leave in FIFO order.
// Backpressure: a push to a full lane with no pop is dropped and flagged on drop; clr empties the lane.
module vpu_lane_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         push,
   input  logic [W-1:0] push_dat,
   input  logic         pop,
   output logic         avail,
   output logic [W-1:0] head_dat,
   output logic         drop
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [W-1:0]     mem_q [DEPTH];
   logic [W-1:0]     mem_d [DEPTH];
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic empty;
   logic full;
   logic store;
   logic pop_mem;

   // An empty lane presents the incoming datum directly so a row can complete
   // in the same cycle its last lane arrives.
   always_comb begin
      empty    = (cnt_q == '0);
      full     = (cnt_q == CNT_W'(DEPTH));
      avail    = !empty || push;
      head_dat = empty ? push_dat : mem_q[rd_ptr_q];
      pop_mem  = pop && !empty;
      store    = push && !(pop && empty) && (!full || pop);
      drop     = push && full && !pop;
   end

   // Pointer, count and storage update; clr wins over any push or pop.
   always_comb begin
      mem_d    = mem_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      cnt_d    = cnt_q;
      if (clr) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         cnt_d    = '0;
      end else begin
         if (store) begin
            mem_d[wr_ptr_q] = push_dat;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
         end
         if (pop_mem) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
         end
         case ({store, pop_mem})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
         endcase
      end
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         mem_q    <= mem_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         cnt_q    <= cnt_d;
      end
   end
endmodule

// Purpose: deskew skewed VPU lane outputs and write full rows to the buffer at strided addresses.
// Latency: wr_valid rises 1 cycle after the last lane of a row is presented; 1 row/cycle sustained.
// Backpressure: wr_ready=0 holds wr_addr/wr_data and stalls pops; lanes keep filling, overflow is sticky.
module vpu_out_collector #(
   parameter int O_WIDTH       = 8,
   parameter int CHANNEL_WIDTH = 16,
   parameter int FIFO_DEPTH    = 4,
   parameter int ADDR_WIDTH    = 16,
   parameter int CNT_WIDTH     = 8
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic                                  start,
   input  logic [ADDR_WIDTH-1:0]                 base_addr,
   input  logic [ADDR_WIDTH-1:0]                 row_stride,
   input  logic [CNT_WIDTH-1:0]                  row_count,
   input  logic [CHANNEL_WIDTH-1:0]              vpu_out_valid,
   input  logic [CHANNEL_WIDTH-1:0][O_WIDTH-1:0] vpu_out,
   output logic                                  wr_valid,
   input  logic                                  wr_ready,
   output logic [ADDR_WIDTH-1:0]                 wr_addr,
   output logic [CHANNEL_WIDTH*O_WIDTH-1:0]      wr_data,
   output logic                                  busy,
   output logic                                  done,
   output logic                                  overflow
);
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_FIN  = 2'd2
   } state_t;

   localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

   state_t state_q, state_d;

   logic [ADDR_WIDTH-1:0]            next_addr_q, next_addr_d;
   logic [ADDR_WIDTH-1:0]            stride_q, stride_d;
   logic [CNT_WIDTH-1:0]             count_q, count_d;
   logic [CNT_WIDTH-1:0]             issued_q, issued_d;
   logic [CNT_WIDTH-1:0]             acked_q, acked_d;
   logic                             overflow_q, overflow_d;
   logic                             wr_valid_q, wr_valid_d;
   logic [ADDR_WIDTH-1:0]            wr_addr_q, wr_addr_d;
   logic [CHANNEL_WIDTH*O_WIDTH-1:0] wr_data_q, wr_data_d;

   logic [CHANNEL_WIDTH-1:0]             lane_push;
   logic [CHANNEL_WIDTH-1:0]             lane_avail;
   logic [CHANNEL_WIDTH-1:0]             lane_drop;
   logic [CHANNEL_WIDTH-1:0][O_WIDTH-1:0] lane_head;
   logic [CHANNEL_WIDTH*O_WIDTH-1:0]     row_dat;

   logic run;
   logic fifo_clr;
   logic start_acc;
   logic row_pop;
   logic wr_hs;
   logic last_hs;

   // Lane FIFOs only fill while running; outside RUN they are held empty, which
   // both clears them on start and discards leftovers once the job finishes.
   always_comb begin
      run       = (state_q == ST_RUN);
      fifo_clr  = !run;
      start_acc = (state_q == ST_IDLE) && start;
      lane_push = run ? vpu_out_valid : '0;
      wr_hs     = wr_valid_q && wr_ready;
      last_hs   = wr_hs && ((acked_q + CNT_ONE) == count_q);
      row_pop   = run && (&lane_avail) && (!wr_valid_q || wr_ready)
                  && (issued_q != count_q);
   end

   for (genvar g = 0; g < CHANNEL_WIDTH; g++) begin : g_lane
      vpu_lane_fifo #(
         .W     (O_WIDTH),
         .DEPTH (FIFO_DEPTH)
      ) u_fifo (
         .clk      (clk),
         .rst      (rst),
         .clr      (fifo_clr),
         .push     (lane_push[g]),
         .push_dat (vpu_out[g]),
         .pop      (row_pop),
         .avail    (lane_avail[g]),
         .head_dat (lane_head[g]),
         .drop     (lane_drop[g])
      );
      assign row_dat[g*O_WIDTH +: O_WIDTH] = lane_head[g];
   end

   // Job FSM: a zero-row job passes straight through FIN so done still pulses.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = (row_count == '0) ? ST_FIN : ST_RUN;
            end
         end
         ST_RUN: begin
            if (last_hs) begin
               state_d = ST_FIN;
            end
         end
         ST_FIN:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Job parameters, row/ack counters, address accumulator and output register.
   always_comb begin
      next_addr_d = next_addr_q;
      stride_d    = stride_q;
      count_d     = count_q;
      issued_d    = issued_q;
      acked_d     = acked_q;
      overflow_d  = overflow_q;
      wr_valid_d  = wr_valid_q;
      wr_addr_d   = wr_addr_q;
      wr_data_d   = wr_data_q;
      if (start_acc) begin
         next_addr_d = base_addr;
         stride_d    = row_stride;
         count_d     = row_count;
         issued_d    = '0;
         acked_d     = '0;
         overflow_d  = 1'b0;
      end
      if (row_pop) begin
         wr_valid_d  = 1'b1;
         wr_data_d   = row_dat;
         wr_addr_d   = next_addr_q;
         next_addr_d = next_addr_q + stride_q;
         issued_d    = issued_q + CNT_ONE;
      end else if (wr_hs) begin
         wr_valid_d = 1'b0;
      end
      if (wr_hs) begin
         acked_d = acked_q + CNT_ONE;
      end
      if (|lane_drop) begin
         overflow_d = 1'b1;
      end
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         next_addr_q <= '0;
         stride_q    <= '0;
         count_q     <= '0;
         issued_q    <= '0;
         acked_q     <= '0;
         overflow_q  <= 1'b0;
         wr_valid_q  <= 1'b0;
         wr_addr_q   <= '0;
         wr_data_q   <= '0;
      end else begin
         state_q     <= state_d;
         next_addr_q <= next_addr_d;
         stride_q    <= stride_d;
         count_q     <= count_d;
         issued_q    <= issued_d;
         acked_q     <= acked_d;
         overflow_q  <= overflow_d;
         wr_valid_q  <= wr_valid_d;
         wr_addr_q   <= wr_addr_d;
         wr_data_q   <= wr_data_d;
      end
   end

   // Output drive.
   always_comb begin
      wr_valid = wr_valid_q;
      wr_addr  = wr_addr_q;
      wr_data  = wr_data_q;
      overflow = overflow_q;
      busy     = (state_q != ST_IDLE);
      done     = (state_q == ST_FIN);
   end
endmodule

// File: doc/vpu_out_collector.md
Name: vpu_out_collector

Overview:
- Receive end of the VPU channel output: consumes the per-lane vpu_out_valid/vpu_out streams, which arrive skewed across lanes by the systolic array diagonal.
- Deskews them in per-lane FIFOs and assembles full CHANNEL_WIDTH-wide rows.
- Writes each row to the unified buffer over a valid/ready write port, at sequential strided addresses.
- Sits between vpu_channel outputs and the output buffer; controlled by the tile sequencer through start/done.

Parameters:
- O_WIDTH, 8: lane data width; matches the VPU output width.
- CHANNEL_WIDTH, 16: number of lanes.
- FIFO_DEPTH, 4: entries per lane FIFO; power of two, >=2.
- ADDR_WIDTH, 16: buffer address width.
- CNT_WIDTH, 8: row counter width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-low reset (0 = reset).
- start  in  1  one-cycle pulse; starts a job; honoured only in IDLE.
- base_addr  in  ADDR_WIDTH  first row address; latched on start.
- row_stride  in  ADDR_WIDTH  address increment per row; latched on start.
- row_count  in  CNT_WIDTH  rows in the job; latched on start.
- vpu_out_valid  in  [CHANNEL_WIDTH-1:0] x1  per-lane valid.
- vpu_out  in  [CHANNEL_WIDTH-1:0] x O_WIDTH  per-lane data.
- wr_valid  out  1  write request.
- wr_ready  in  1  buffer accepts the write.
- wr_addr  out  ADDR_WIDTH  write address.
- wr_data  out  CHANNEL_WIDTH*O_WIDTH  packed row; lane i at bits [i*O_WIDTH +: O_WIDTH].
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse at job end.
- overflow  out  1  sticky lane-FIFO overflow flag.

Behaviour:
- Reset (rst=0 at a clk edge), all outputs:
  - wr_valid=0, wr_addr=0, wr_data=0, busy=0, done=0, overflow=0.
  - FSM=IDLE; all FIFOs empty; counters cleared.
  - Reset mid-job discards all buffered data and any pending write, with no done pulse.
- FSM: IDLE, RUN, FIN.
  - IDLE->RUN on start with row_count!=0.
  - start with row_count==0: IDLE->FIN directly.
  - RUN->FIN when the row_count-th write handshake completes (wr_valid&wr_ready).
  - FIN->IDLE unconditionally. done=1 only during the FIN cycle.
  - start while busy is ignored.
- On start:
  - Latch base_addr, row_stride, row_count.
  - Clear overflow, row counter, and all FIFOs.
  - wr_addr is set to base_addr when the first row is loaded.
- Lane push:
  - In RUN, lane i pushes vpu_out[i] when vpu_out_valid[i]=1.
  - Valids in IDLE/FIN are ignored; nothing is stored and overflow is not set.
- Full lane:
  - If lane i is full and no pop occurs that cycle, the datum is dropped and overflow is set (sticky until the next start or reset).
  - A push to a full lane in the same cycle as a row pop is accepted, with no overflow.
- Row pop: occurs when every lane FIFO is non-empty AND the output register is free (wr_valid=0 OR wr_ready=1). One entry is removed from every lane simultaneously.
- Output register:
  - Popped row is registered into wr_data; wr_valid=1 the next cycle.
  - wr_addr = base_addr + k*row_stride for the k-th row (k from 0), computed by an accumulating adder, modulo 2^ADDR_WIDTH (wrap allowed).
  - While wr_valid=1 and wr_ready=0, wr_data and wr_addr hold stable.
- Latency and throughput:
  - Latency from the last lane completing a row to wr_valid is exactly 1 cycle.
  - With wr_ready held at 1 and all lanes fed each cycle, throughput is 1 row/cycle.
- Job end:
  - Rows beyond row_count are never issued.
  - After the final pop, the remaining lane contents are discarded on the FIN transition.
- Empty and skew handling:
  - No lane empty: no pop.
  - Lane skew of up to FIFO_DEPTH-1 cycles between the earliest and latest lane is absorbed losslessly at full rate.

Test Plan:
- Aligned stream: start with base=0x100, stride=0x10, count=3; all 16 lanes valid with data=row*16+lane for 3 cycles; wr_ready=1.
  -> Writes at 0x100, 0x110, 0x120, each 1 cycle after its inputs.
  -> Lane 5 of row 2 = 37.
  -> done pulses one cycle after the third handshake; busy then drops.
- Diagonal skew: lane i starts i cycles late, count=4, FIFO_DEPTH=4.
  -> Exactly 4 rows with the correct per-lane data; overflow=0.
- Backpressure: wr_ready=0 for 5 cycles mid-job.
  -> wr_data and wr_addr stay stable, no rows lost or duplicated.
  -> Pushing a 5th entry into a full lane with no pop sets overflow=1, and it stays 1 until the next start.
- row_count=0: start.
  -> busy=1 for one cycle, done=1 that same cycle, no wr_valid.
- Reset mid-job: drive rst=0 for one cycle while wr_valid=1.
  -> All outputs are 0 next cycle.
  -> A subsequent start with count=1 produces exactly one fresh write at the new base_addr.
- Address wrap: base=0xFFF0, stride=0x10, count=2.
  -> Writes at 0xFFF0 then 0x0000.
